dm_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path and port 1 is the debug/display readback or DMA path.
- Sits between the requesters and the DM instance.
- Serializes accesses with a 3-state FSM, round-robin arbitration and a fixed-latency read return.
- Gives the display logic non-intrusive memory reads while the core runs.

---
 rtl/dm_arb_pkg.sv | 22 ++
 rtl/dm_arbiter_if.sv | 52 +++++
 rtl/dm_arbiter_rr_arb2.sv | 21 ++
 rtl/dm_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dm_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, latched command payload
// and the read-latency counter width.
package dm_arb_pkg;

  localparam int unsigned DM_ADDR_W = 32;
  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic                 id;
    logic                 we;
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester, memory and status signals of the data-memory arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if #(
  parameter int unsigned ADDR_W = dm_arb_pkg::DM_ADDR_W,
  parameter int unsigned DATA_W = dm_arb_pkg::DM_DATA_W
);

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: a lone request wins, a tie goes to
// the port that did not win last.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_id_c,
  output logic       o_valid_c
);

  always_comb begin
    o_valid_c = |i_req;
    o_id_c    = 1'b0;
    case (i_req)
      2'b01:   o_id_c = 1'b0;
      2'b10:   o_id_c = 1'b1;
      2'b11:   o_id_c = ~i_last;
      default: o_id_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port data memory (IDLE/ISSUE/WAIT FSM).
// Define DM_ARB_PERF_EN to add saturating grant/conflict performance counters.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  dm_arbiter_if.slave        bus
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_gnt0,
  output logic [31:0]        perf_gnt1,
  output logic [31:0]        perf_conflict
`endif
);

  state_t            r_state, w_state_nxt;
  cmd_t              r_cmd, w_cmd_nxt;
  logic              r_last, w_last_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic [1:0]        r_rvalid, w_rvalid_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
  logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;
  logic              r_busy, w_busy_nxt;

  logic [1:0]        w_req;
  logic              w_pick_id;
  logic              w_pick_valid;

  assign w_req = {bus.r1_req, bus.r0_req};

  rr_arb2 u_rr_arb2 (
    .i_req     (w_req),
    .i_last    (r_last),
    .o_id_c    (w_pick_id),
    .o_valid_c (w_pick_valid)
  );

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_nxt    = r_cmd;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_gnt_nxt    = 2'b00;
    w_rvalid_nxt = 2'b00;
    w_mem_en_nxt = 1'b0;
    w_mem_we_nxt = 1'b0;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_cmd_nxt.id = w_pick_id;
          if (w_pick_id) begin
            w_cmd_nxt.we    = bus.r1_we;
            w_cmd_nxt.addr  = DM_ADDR_W'(bus.r1_addr);
            w_cmd_nxt.wdata = DM_DATA_W'(bus.r1_wdata);
            w_gnt_nxt       = 2'b10;
          end else begin
            w_cmd_nxt.we    = bus.r0_we;
            w_cmd_nxt.addr  = DM_ADDR_W'(bus.r0_addr);
            w_cmd_nxt.wdata = DM_DATA_W'(bus.r0_wdata);
            w_gnt_nxt       = 2'b01;
          end
          w_last_nxt   = w_pick_id;
          w_mem_en_nxt = 1'b1;
          w_mem_we_nxt = w_cmd_nxt.we;
          w_state_nxt  = ISSUE;
        end
      end

      ISSUE: begin
        if (r_cmd.we) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = CNT_W'(MEM_LAT);
          w_state_nxt = WAIT;
        end
      end

      WAIT: begin
        // Memory data is valid in the cycle the counter sits at 1.
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt = '0;
          if (r_cmd.id) begin
            w_rdata1_nxt = bus.mem_rdata;
            w_rvalid_nxt = 2'b10;
          end else begin
            w_rdata0_nxt = bus.mem_rdata;
            w_rvalid_nxt = 2'b01;
          end
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cmd    <= '0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_gnt    <= 2'b00;
      r_rvalid <= 2'b00;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cmd    <= w_cmd_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_mem_en <= w_mem_en_nxt;
      r_mem_we <= w_mem_we_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.r0_gnt    = r_gnt[0];
  assign bus.r1_gnt    = r_gnt[1];
  assign bus.r0_rvalid = r_rvalid[0];
  assign bus.r1_rvalid = r_rvalid[1];
  assign bus.r0_rdata  = r_rdata0;
  assign bus.r1_rdata  = r_rdata1;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = ADDR_W'(r_cmd.addr);
  assign bus.mem_wdata = DATA_W'(r_cmd.wdata);
  assign bus.busy      = r_busy;

`ifdef DM_ARB_PERF_EN
  logic [31:0] r_perf_gnt0;
  logic [31:0] r_perf_gnt1;
  logic [31:0] r_perf_conflict;

  // Saturating counters; a conflict cycle is any request seen without a grant out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_gnt0     <= '0;
      r_perf_gnt1     <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (r_gnt[0] && (r_perf_gnt0 != 32'hFFFF_FFFF)) begin
        r_perf_gnt0 <= r_perf_gnt0 + 32'd1;
      end
      if (r_gnt[1] && (r_perf_gnt1 != 32'hFFFF_FFFF)) begin
        r_perf_gnt1 <= r_perf_gnt1 + 32'd1;
      end
      if ((|w_req) && (r_gnt == 2'b00) && (r_perf_conflict != 32'hFFFF_FFFF)) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
    end
  end

  assign perf_gnt0     = r_perf_gnt0;
  assign perf_gnt1     = r_perf_gnt1;
  assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a small memory model with the matching read latency.
module tb_dm_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

`ifdef DM_ARB_PERF_EN
  logic [31:0] pa_g0, pa_g1, pa_c;
  logic [31:0] pb_g0, pb_g1, pb_c;
`endif

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
`ifdef DM_ARB_PERF_EN
    ,
    .perf_gnt0     (pa_g0),
    .perf_gnt1     (pa_g1),
    .perf_conflict (pa_c)
`endif
  );

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
`ifdef DM_ARB_PERF_EN
    ,
    .perf_gnt0     (pb_g0),
    .perf_gnt1     (pb_g1),
    .perf_conflict (pb_c)
`endif
  );

  // Memory A: one-cycle read latency; idle cycles return a poison pattern.
  logic [31:0] mem_a [256];
  logic [31:0] rd_a;
  always @(posedge clk) begin
    if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    rd_a <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr[7:0]] : 32'hBAD0_BAD0;
  end
  assign bus_a.mem_rdata = rd_a;

  // Memory B: three-cycle read latency through a delay line.
  logic [31:0] mem_b [256];
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
    pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr[7:0]] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_b.mem_rdata = pipe_b[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus_a.r0_req   = req;
    bus_a.r0_we    = we;
    bus_a.r0_addr  = addr;
    bus_a.r0_wdata = wdata;
  endtask

  task automatic drive_a1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus_a.r1_req   = req;
    bus_a.r1_we    = we;
    bus_a.r1_addr  = addr;
    bus_a.r1_wdata = wdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [4];
    int ng;
    int busy_cycles;
    int rv_at;

    rst = 1'b1;
    drive_a0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_a1(1'b0, 1'b0, 32'h0, 32'h0);
    bus_b.r0_req = 1'b0; bus_b.r0_we = 1'b0; bus_b.r0_addr = '0; bus_b.r0_wdata = '0;
    bus_b.r1_req = 1'b0; bus_b.r1_we = 1'b0; bus_b.r1_addr = '0; bus_b.r1_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[8'h10] = 32'hDEAD_BEEF;
    mem_b[8'h30] = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) pipe_b[i] = 32'h0;
    rd_a = 32'h0;
    do_reset();

    // Reset state
    check("rst_busy",   32'(bus_a.busy), 32'd0);
    check("rst_gnt",    32'({bus_a.r1_gnt, bus_a.r0_gnt}), 32'd0);
    check("rst_rvalid", 32'({bus_a.r1_rvalid, bus_a.r0_rvalid}), 32'd0);
    check("rst_mem",    32'({bus_a.mem_en, bus_a.mem_we}), 32'd0);
    check("rst_maddr",  bus_a.mem_addr, 32'h0);
    check("rst_rdata0", bus_a.r0_rdata, 32'h0);
    check("rst_rdata1", bus_a.r1_rdata, 32'h0);

    // Port 0 read of 0x10, request held in cycle T
    drive_a0(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    check("rd_gnt0",   32'(bus_a.r0_gnt), 32'd1);
    check("rd_gnt1",   32'(bus_a.r1_gnt), 32'd0);
    check("rd_mem_en", 32'(bus_a.mem_en), 32'd1);
    check("rd_mem_we", 32'(bus_a.mem_we), 32'd0);
    check("rd_maddr",  bus_a.mem_addr, 32'h10);
    drive_a0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("rd_wait_en",  32'(bus_a.mem_en), 32'd0);
    check("rd_wait_rv",  32'(bus_a.r0_rvalid), 32'd0);
    check("rd_wait_bsy", 32'(bus_a.busy), 32'd1);
    tick();
    check("rd_rvalid0", 32'(bus_a.r0_rvalid), 32'd1);
    check("rd_rdata0",  bus_a.r0_rdata, 32'hDEAD_BEEF);
    check("rd_rvalid1", 32'(bus_a.r1_rvalid), 32'd0);
    check("rd_rdata1",  bus_a.r1_rdata, 32'h0);
    check("rd_busy",    32'(bus_a.busy), 32'd0);
    tick();
    check("rd_rv_pulse", 32'(bus_a.r0_rvalid), 32'd0);

    // Port 1 write 0x20, then port 0 reads it back
    drive_a1(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    tick();
    check("wr_gnt1",  32'({bus_a.r1_gnt, bus_a.r0_gnt}), 32'b10);
    check("wr_mem",   32'({bus_a.mem_en, bus_a.mem_we}), 32'b11);
    check("wr_maddr", bus_a.mem_addr, 32'h20);
    check("wr_wdata", bus_a.mem_wdata, 32'h1234_5678);
    drive_a1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("wr_we_once", 32'({bus_a.mem_en, bus_a.mem_we}), 32'b00);
    check("wr_busy",    32'(bus_a.busy), 32'd0);
    drive_a0(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    check("rb_gnt0", 32'(bus_a.r0_gnt), 32'd1);
    drive_a0(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    check("rb_rvalid0", 32'(bus_a.r0_rvalid), 32'd1);
    check("rb_rdata0",  bus_a.r0_rdata, 32'h1234_5678);
    check("rb_rdata1",  bus_a.r1_rdata, 32'h0);

    // Both ports reading continuously after reset: expect grants 0,1,0,1
    do_reset();
    drive_a0(1'b1, 1'b0, 32'h10, 32'h0);
    drive_a1(1'b1, 1'b0, 32'h20, 32'h0);
    ng = 0;
    for (int k = 0; k < 20 && ng < 4; k++) begin
      tick();
      check("rr_gnt_excl", 32'(bus_a.r0_gnt & bus_a.r1_gnt), 32'd0);
      check("rr_rv_excl",  32'(bus_a.r0_rvalid & bus_a.r1_rvalid), 32'd0);
      if (bus_a.r0_gnt) begin
        order[ng] = 0;
        ng++;
      end else if (bus_a.r1_gnt) begin
        order[ng] = 1;
        ng++;
      end
    end
    drive_a0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_a1(1'b0, 1'b0, 32'h0, 32'h0);
    check("rr_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
    end
    repeat (3) tick();
    check("rr_rdata0", bus_a.r0_rdata, 32'hDEAD_BEEF);
    check("rr_rdata1", bus_a.r1_rdata, 32'h1234_5678);

    // MEM_LAT=3 instance: rvalid 5 cycles after sampling, busy for 4 cycles
    bus_b.r0_req = 1'b1; bus_b.r0_we = 1'b0; bus_b.r0_addr = 32'h30;
    busy_cycles = 0;
    rv_at = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        check("l3_gnt0", 32'(bus_b.r0_gnt), 32'd1);
        bus_b.r0_req = 1'b0;
      end
      if (bus_b.busy) busy_cycles++;
      if (bus_b.r0_rvalid && rv_at < 0) begin
        rv_at = k;
        check("l3_rdata0", bus_b.r0_rdata, 32'hCAFE_F00D);
      end
    end
    check("l3_rv_cycle", 32'(rv_at), 32'd5);
    check("l3_busy_cyc", 32'(busy_cycles), 32'd4);

    // Reset pulsed while port 1's read is in WAIT
    drive_a1(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    check("rw_gnt1", 32'(bus_a.r1_gnt), 32'd1);
    drive_a1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("rw_in_wait", 32'(bus_a.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_no_rv",  32'({bus_a.r1_rvalid, bus_a.r0_rvalid}), 32'd0);
    check("rw_busy",   32'(bus_a.busy), 32'd0);
    check("rw_outs",   32'({bus_a.r1_gnt, bus_a.r0_gnt, bus_a.mem_en, bus_a.mem_we}), 32'd0);
    check("rw_maddr",  bus_a.mem_addr, 32'h0);
    check("rw_rdata0", bus_a.r0_rdata, 32'h0);
    check("rw_rdata1", bus_a.r1_rdata, 32'h0);
    tick();
    check("rw_no_rv2", 32'(bus_a.r1_rvalid), 32'd0);
    drive_a0(1'b1, 1'b0, 32'h10, 32'h0);
    drive_a1(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    check("rw_tie", 32'({bus_a.r1_gnt, bus_a.r0_gnt}), 32'b01);
    drive_a0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_a1(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();

`ifdef DM_ARB_PERF_EN
    // Two conflicting reads: port 1 waits three request-without-grant cycles
    do_reset();
    check("pf_rst_g0", pa_g0, 32'd0);
    check("pf_rst_c",  pa_c,  32'd0);
    drive_a0(1'b1, 1'b0, 32'h10, 32'h0);
    drive_a1(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    check("pf_gnt0_seen", 32'(bus_a.r0_gnt), 32'd1);
    drive_a0(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    check("pf_gnt1_seen", 32'(bus_a.r1_gnt), 32'd1);
    drive_a1(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();
    check("pf_gnt0",     pa_g0, 32'd1);
    check("pf_gnt1",     pa_g1, 32'd1);
    check("pf_conflict", pa_c,  32'd3);
    check("pf_b_gnt1",   pb_g1, 32'd0);
    check("pf_b_c",      pb_c,  32'd0);
    check("pf_b_g0",     pb_g0, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
